// File: rtl/xpto_arb.sv
// -----------------------------------------------------------------------------
// xpto_arb
// Round-robin controller that shares one xpto datapath between two requesters.
// One operand is accepted at a time, issued to the datapath with a single
// x_is_valid pulse, and the datapath result is returned to the requester
// that supplied the operand.
//
// Optional feature macro: XPTO_ARB_TIMEOUT_EN
//   defined   : WAIT is bounded by TIMEOUT cycles; on expiry a zero result is
//               returned with rsp_err = 1.
//   undefined : WAIT lasts until the datapath answers; rsp_err is tied to 0.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req0_x/_valid/_ready     requester 0 operand handshake
//   req1_x/_valid/_ready     requester 1 operand handshake
//   rsp0_y/_valid            requester 0 result, one-cycle valid pulse
//   rsp1_y/_valid            requester 1 result, one-cycle valid pulse
//   rsp_err                  timeout flag, qualified by rspN_valid
//   dp_x, dp_x_is_valid      to the xpto datapath
//   dp_y, dp_y_is_valid      from the xpto datapath
// -----------------------------------------------------------------------------
module xpto_arb #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req0_x,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic             req1_valid,
    output logic             req1_ready,
    output logic [WIDTH-1:0] rsp0_y,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp1_y,
    output logic             rsp1_valid,
    output logic             rsp_err,
    output logic [WIDTH-1:0] dp_x,
    output logic             dp_x_is_valid,
    input  logic [WIDTH-1:0] dp_y,
    input  logic             dp_y_is_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic             last_grant_reg;
    logic             grant_reg;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic             win_id;
    logic             accept;
    logic             timed_out;

`ifdef XPTO_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    logic [CW-1:0] cnt_reg;
    logic          err_reg;

    // cnt_reg holds the number of WAIT cycles already spent, so the cycle in
    // which it equals TIMEOUT-1 is the last permitted WAIT cycle.
    assign timed_out = (state_reg == WAIT) && !dp_y_is_valid &&
                       (cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (state_reg == ISSUE) begin
                cnt_reg <= '0;
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == WAIT) begin
                if (dp_y_is_valid) begin
                    err_reg <= 1'b0;
                end else if (timed_out) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign rsp_err = err_reg && (state_reg == RESP);
`else
    assign timed_out = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // Requester 1 wins when it is the only one asking, or on a tie when
    // requester 0 had the previous grant.
    always_comb begin
        state_next    = state_reg;
        win_id        = req1_valid && (!req0_valid || !last_grant_reg);
        accept        = 1'b0;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        dp_x_is_valid = 1'b0;
        rsp0_valid    = 1'b0;
        rsp1_valid    = 1'b0;
        case (state_reg)
            IDLE: begin
                req0_ready = req0_valid && !win_id;
                req1_ready = win_id;
                accept     = req0_valid || req1_valid;
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                dp_x_is_valid = 1'b1;
                state_next    = WAIT;
            end
            WAIT: begin
                if (dp_y_is_valid || timed_out) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp0_valid = !grant_reg;
                rsp1_valid = grant_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            x_reg          <= '0;
            y_reg          <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                x_reg          <= win_id ? req1_x : req0_x;
                grant_reg      <= win_id;
                last_grant_reg <= win_id;
            end
            if (state_reg == WAIT && dp_y_is_valid) begin
                y_reg <= dp_y;
            end else if (timed_out) begin
                y_reg <= '0;
            end
        end
    end

    assign dp_x   = x_reg;
    assign rsp0_y = y_reg;
    assign rsp1_y = y_reg;

endmodule

// File: tb/tb_xpto_arb.sv
// -----------------------------------------------------------------------------
// tb_xpto_arb
// Directed bench for xpto_arb. A behavioural datapath returns y = x + 1 two
// cycles after x_is_valid; y_force injects stray y_is_valid pulses.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_xpto_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req0_x, req1_x;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] rsp0_y, rsp1_y;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp_err;
    logic [3:0] dp_x;
    logic       dp_x_is_valid;
    logic [3:0] dp_y;
    logic       dp_y_is_valid;

    logic       model_on = 1'b1;
    logic       y_force  = 1'b0;
    logic       v1 = 1'b0, v2 = 1'b0;
    logic [3:0] d1 = 4'd0, d2 = 4'd0;
    int         xv_cnt = 0;

    int checks = 0;
    int errors = 0;

    xpto_arb #(.WIDTH(4), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_x       (req0_x),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req1_x       (req1_x),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .rsp0_y       (rsp0_y),
        .rsp0_valid   (rsp0_valid),
        .rsp1_y       (rsp1_y),
        .rsp1_valid   (rsp1_valid),
        .rsp_err      (rsp_err),
        .dp_x         (dp_x),
        .dp_x_is_valid(dp_x_is_valid),
        .dp_y         (dp_y),
        .dp_y_is_valid(dp_y_is_valid)
    );

    always #5 clk = ~clk;

    // Datapath model: two-stage pipeline, y = x + 1, wraps at 4 bits.
    always @(posedge clk) begin
        v1 <= dp_x_is_valid && model_on;
        d1 <= dp_x + 4'd1;
        v2 <= v1;
        d2 <= d1;
    end
    assign dp_y_is_valid = v2 || y_force;
    assign dp_y          = d2;

    always @(negedge clk) begin
        if (dp_x_is_valid === 1'b1) xv_cnt++;
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Waits up to limit falling edges for a response pulse. port = -1 when
    // none arrives, 2 when both ports pulse together; n = edges waited.
    task automatic wait_rsp(input int limit, output int port, output int y,
                            output int n, output int err);
        port = -1; y = 0; n = 0; err = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) begin
                port = (rsp0_valid && rsp1_valid) ? 2 : (rsp1_valid ? 1 : 0);
                y    = rsp0_valid ? int'(rsp0_y) : int'(rsp1_y);
                err  = int'(rsp_err);
                n    = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, y, n, e, xv0;

        rst = 1'b1;
        req0_x = 4'd0; req1_x = 4'd0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_dp_x_valid", dp_x_is_valid, 0);
        check("rst_dp_x", dp_x, 0);
        check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("rst_rsp_y", rsp0_y, 0);
        check("rst_rsp_err", rsp_err, 0);

        // Single request from requester 0
        rst = 1'b0;
        req0_valid = 1'b1; req0_x = 4'd5;
        #1;
        check("t1_ready0", req0_ready, 1);
        check("t1_ready1", req1_ready, 0);
        @(negedge clk);
        check("t1_issue_valid", dp_x_is_valid, 1);
        check("t1_issue_x", dp_x, 5);
        check("t1_ready0_after", req0_ready, 0);
        req0_valid = 1'b0;
        @(negedge clk);
        check("t1_wait_valid", dp_x_is_valid, 0);
        check("t1_wait_x", dp_x, 5);
        // RESP falls 4 cycles after the accept cycle, i.e. 2 after this one
        wait_rsp(10, p, y, n, e);
        check("t1_port", p, 0);
        check("t1_y", y, 6);
        check("t1_latency", n, 2);
        check("t1_err", e, 0);
        @(negedge clk);
        check("t1_rsp_gone", {rsp0_valid, rsp1_valid}, 0);
        check("t1_y_hold", rsp1_y, 6);

        // Continuous contention after reset: grants alternate starting with 0
        do_reset();
        req0_x = 4'd3; req1_x = 4'd9;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        xv0 = xv_cnt;
        for (int k = 0; k < 6; k++) begin
            wait_rsp(12, p, y, n, e);
            check($sformatf("rr%0d_port", k), p, k % 2);
            check($sformatf("rr%0d_y", k), y, (k % 2) ? 10 : 4);
            check($sformatf("rr%0d_gap", k), n, (k == 0) ? 4 : 5);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rr_x_pulses", xv_cnt - xv0, 6);

        // Reset while in WAIT
        req0_valid = 1'b1; req0_x = 4'd7;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        check("rw_wait_x", dp_x, 7);
        rst = 1'b1;
        #1;
        check("rw_dp_x", dp_x, 0);
        check("rw_dp_x_valid", dp_x_is_valid, 0);
        check("rw_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("rw_rsp_y", rsp0_y, 0);
        @(negedge clk);
        rst = 1'b0;
        req0_x = 4'd11; req1_x = 4'd12;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rw_ready0", req0_ready, 1);
        check("rw_ready1", req1_ready, 0);
        wait_rsp(12, p, y, n, e);
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rw_port", p, 0);
        check("rw_y", y, 12);
        check("rw_latency", n, 4);

        // Wrap-around data on requester 1
        req1_valid = 1'b1; req1_x = 4'd15;
        wait_rsp(12, p, y, n, e);
        req1_valid = 1'b0;
        check("wr_port", p, 1);
        check("wr_y", y, 0);
        check("wr_shared_y", rsp0_y, 0);

        // Stray dp_y_is_valid in IDLE produces nothing
        y_force = 1'b1;
        @(negedge clk);
        y_force = 1'b0;
        wait_rsp(6, p, y, n, e);
        check("stray_idle_port", p, -1);

        // Datapath that never answers
        model_on = 1'b0;
        req0_valid = 1'b1; req0_x = 4'd2;
        @(negedge clk);
        req0_valid = 1'b0;
`ifdef XPTO_ARB_TIMEOUT_EN
        // ISSUE now, 15 WAIT cycles, then RESP
        wait_rsp(30, p, y, n, e);
        check("to_port", p, 0);
        check("to_latency", n, 16);
        check("to_y", y, 0);
        check("to_err", e, 1);
        y_force = 1'b1;
        @(negedge clk);
        y_force = 1'b0;
        wait_rsp(6, p, y, n, e);
        check("to_late_port", p, -1);
`else
        wait_rsp(30, p, y, n, e);
        check("hang_port", p, -1);
        check("hang_x", dp_x, 2);
        check("hang_err", rsp_err, 0);
        do_reset();
`endif
        model_on = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xpto_arb.md
# xpto_arb

Round-robin controller that shares one `xpto` 4-bit datapath between two requesters. It accepts one operand at a time from either port, issues it to the datapath with a one-cycle `x_is_valid` pulse, and waits for `y_is_valid`. It then returns the result to the requester that issued the operand. The block sits between the requester logic and the single `xpto` instance, and owns all of that instance's input and output ports.

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width; must match `xpto`.
- `TIMEOUT`, default 15: maximum number of WAIT cycles. Used only when `XPTO_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: reset; asynchronous, active-high.
- `req0_x`, input, WIDTH: requester 0 operand.
- `req0_valid`, input, 1: requester 0 has an operand.
- `req0_ready`, output, 1: requester 0 operand accepted this cycle.
- `req1_x`, `req1_valid`, `req1_ready`: same three signals for requester 1.
- `rsp0_y`, output, WIDTH: result for requester 0.
- `rsp0_valid`, output, 1: one-cycle pulse; `rsp0_y` is valid.
- `rsp1_y`, `rsp1_valid`: same two signals for requester 1.
- `rsp_err`, output, 1: timeout flag; qualified by `rspN_valid`.
- `dp_x`, output, WIDTH: drives `xpto.x`.
- `dp_x_is_valid`, output, 1: drives `xpto.x_is_valid`.
- `dp_y`, input, WIDTH: from `xpto.y`.
- `dp_y_is_valid`, input, 1: from `xpto.y_is_valid`.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If exactly one `reqN_valid` is high, that requester wins.
  - If both are high, the requester other than `last_grant` wins.
  - `reqN_ready` for the winner is combinational: asserted only in IDLE, and only for the winner.
  - On the handshake (`valid & ready`), the operand and the winner ID are registered, `last_grant` is set to the winner, and the FSM goes to ISSUE.
- **ISSUE:**
  - `dp_x_is_valid` = 1 for exactly one cycle; `dp_x` = the registered operand.
  - The next state is always WAIT.
- **WAIT:**
  - `dp_x_is_valid` = 0; `dp_x` holds the operand.
  - On `dp_y_is_valid` = 1, `dp_y` is registered into the result register and the FSM goes to RESP.
  - `dp_y_is_valid` is ignored in every state except WAIT.
- **RESP:**
  - `rspN_valid` = 1 for one cycle, for the registered winner only. `rspN_y` = the result register.
  - The other response port keeps `valid` = 0.
  - The next state is IDLE.
- **Result hold:** `rsp0_y` and `rsp1_y` both show the shared result register, which holds until the next result is captured.
- **Single outstanding transaction:** the block never accepts a new operand before RESP.
- **Reset values:** state = IDLE, `last_grant` = 1 (so requester 0 wins the first tie), operand and result registers = 0. All outputs are 0, including `reqN_ready`, because `valid` inputs are low while the bench holds reset.
- **Reset mid-operation:** the transaction is abandoned and no response is produced. The requester must re-submit.
- **Data rules:** no arithmetic is applied to operands or results; widths pass through unchanged.

## Timing
- **Accept:** edge E0 (handshake) → ISSUE during cycle E0..E1 → earliest `dp_y_is_valid` sampled at E2 → RESP during cycle E2..E3.
- **Minimum accept-to-response latency:** 3 cycles. Each extra cycle of datapath latency adds 1.
- **Throughput:** one transaction per (datapath latency + 3) cycles.
- **Next accept:** the earliest next accept is the IDLE cycle directly after RESP.
- **Request changes outside IDLE:** a `reqN_valid` that drops or changes outside IDLE has no effect.
- **Datapath arbitration:** the datapath sees at most one `x_is_valid` pulse per transaction.

## Configuration
- **`XPTO_ARB_TIMEOUT_EN` defined:**
  - A 4-bit-minimum counter clears on entry to WAIT and increments on each WAIT cycle.
  - If the counter reaches `TIMEOUT` with no `dp_y_is_valid`, the FSM goes to RESP with result = 0 and `rsp_err` = 1.
  - A late `dp_y_is_valid` after the timeout is ignored.
  - `rsp_err` = 0 for normal responses.
- **Macro not defined:** there is no counter, WAIT lasts indefinitely, and `rsp_err` is tied to 0.

## Test plan
All scenarios use a datapath model that returns y = x + 1 two cycles after `x_is_valid`.
- **Single request:** `req0_x` = 5, `req0_valid` held from release of reset → `req0_ready` for 1 cycle, one `dp_x_is_valid` pulse with `dp_x` = 5, then `rsp0_valid` pulse with `rsp0_y` = 6, 4 cycles after accept; `rsp1_valid` stays 0.
- **Simultaneous requests:** `req0_x` = 3 and `req1_x` = 9 both valid → requester 0 is served first (`rsp0_y` = 4), then requester 1 (`rsp1_y` = 10), then requester 0 again if still valid.
- **Continuous contention:** both valid for 6 transactions → grants alternate 0,1,0,1,0,1 and exactly one `dp_x_is_valid` pulse per transaction.
- **Reset in WAIT:** `rst` asserted for one cycle in WAIT → all outputs 0 immediately, no `rspN_valid`, and the next grant after reset goes to requester 0.
- **Wrap-around data:** `req1_x` = 15 → `rsp1_y` = 0 (the model wraps at 4 bits) and is passed through unchanged.
- **Timeout (`XPTO_ARB_TIMEOUT_EN`, `TIMEOUT` = 15):** the model never responds → RESP after 15 WAIT cycles with `rsp0_y` = 0 and `rsp_err` = 1. A later `dp_y_is_valid` causes no response.
